button_repeater_multi: RTL and testbench



---
 rtl/button_repeater_multi_if.sv | 12 +
 rtl/button_repeater_multi.sv | 173 +++++++++++++++++
 tb/tb_button_repeater_multi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_repeater_multi_if.sv
// Button-side bundle of the multi-channel repeater: raw pins in, level/pulse/held out.
interface button_repeater_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] i_buttons;
    logic [CHANNELS-1:0] o_level;
    logic [CHANNELS-1:0] o_pulse;
    logic [CHANNELS-1:0] o_held;

    modport master (output i_buttons, input o_level, o_pulse, o_held);
    modport slave  (input i_buttons, output o_level, o_pulse, o_held);
endinterface

// File: rtl/button_repeater_multi.sv
// Multi-channel synchronise / debounce / auto-repeat front end driven by a shared tick enable.
module button_repeater_multi #(
    parameter int                  CHANNELS          = 4,
    parameter int                  TICK_DIV          = 12000,
    parameter int                  DEBOUNCE_TICKS    = 10,
    parameter int                  DELAY_TICKS       = 500,
    parameter int                  PERIOD_TICKS      = 100,
    parameter int                  FAST_PERIOD_TICKS = 25,
    parameter int                  ACCEL_AFTER       = 8,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW        = {CHANNELS{1'b1}}
) (
    input logic                    i_clock,
    input logic                    i_reset,
    button_repeater_multi_if.slave bus
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam int CNT_MAX_A = (DELAY_TICKS > PERIOD_TICKS) ? DELAY_TICKS : PERIOD_TICKS;
    localparam int CNT_MAX   = ((CNT_MAX_A > FAST_PERIOD_TICKS) ? CNT_MAX_A : FAST_PERIOD_TICKS) - 1;
    localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int REPS_MAX  = (ACCEL_AFTER > 1) ? ACCEL_AFTER : 1;
    localparam int REPS_W    = $clog2(REPS_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W-1:0]  FAST_LAST   = CNT_W'(FAST_PERIOD_TICKS - 1);
    localparam logic [REPS_W-1:0] REPS_ACCEL  = REPS_W'(ACCEL_AFTER);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [CHANNELS-1:0] level_v;
    logic [CHANNELS-1:0] pulse_v;
    logic [CHANNELS-1:0] held_v;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic              sync1;
        logic              raw_s;
        logic              stable;
        logic [DB_W-1:0]   db_cnt;
        logic [1:0]        state;
        logic [CNT_W-1:0]  cnt;
        logic [REPS_W-1:0] reps;
        logic [CNT_W-1:0]  period_last;
        logic              level;
        logic              pulse;
        logic              held;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                sync1 <= 1'b0;
                raw_s <= 1'b0;
            end else begin
                sync1 <= bus.i_buttons[ch] ^ ACTIVE_LOW[ch];
                raw_s <= sync1;
            end
        end

        // Any tick where raw_s still matches stable restarts the qualification window.
        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                stable <= 1'b0;
                db_cnt <= '0;
            end else if (raw_s == stable) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt == DB_LAST) begin
                    stable <= raw_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        always_comb begin
            period_last = PERIOD_LAST;
            if (ACCEL_AFTER != 0 && reps >= REPS_ACCEL) begin
                period_last = FAST_LAST;
            end
        end

        // A released input wins over any tick or repeat event in the same cycle.
        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                state <= IDLE;
                cnt   <= '0;
                reps  <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
                held  <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (!stable) begin
                    state <= IDLE;
                    cnt   <= '0;
                    reps  <= '0;
                    level <= 1'b0;
                    held  <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            state <= HOLD;
                            cnt   <= '0;
                            pulse <= 1'b1;
                            level <= 1'b1;
                            held  <= 1'b1;
                        end
                        HOLD: begin
                            if (tick) begin
                                if (cnt == DELAY_LAST) begin
                                    state <= REPEAT;
                                    cnt   <= '0;
                                    reps  <= REPS_W'(1);
                                    pulse <= 1'b1;
                                    level <= ~level;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        REPEAT: begin
                            if (tick) begin
                                if (cnt == period_last) begin
                                    cnt   <= '0;
                                    pulse <= 1'b1;
                                    level <= ~level;
                                    if (reps < REPS_ACCEL) begin
                                        reps <= reps + 1'b1;
                                    end
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state <= IDLE;
                            held  <= 1'b0;
                            level <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign level_v[ch] = level;
        assign pulse_v[ch] = pulse;
        assign held_v[ch]  = held;
    end

    assign bus.o_level = level_v;
    assign bus.o_pulse = pulse_v;
    assign bus.o_held  = held_v;
endmodule

// File: tb/tb_button_repeater_multi.sv
// Randomised and directed bench for button_repeater_multi against a tick-arithmetic reference model.
module tb_button_repeater_multi;
    localparam int         TD    = 4;
    localparam int         DB    = 3;
    localparam int         DELAY = 5;
    localparam int         PER   = 3;
    localparam int         FAST  = 1;
    localparam int         ACC   = 2;
    localparam logic [1:0] AL    = 2'b01;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   pulses0;

    button_repeater_multi_if #(.CHANNELS(2)) bus ();

    button_repeater_multi #(
        .CHANNELS(2), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .DELAY_TICKS(DELAY),
        .PERIOD_TICKS(PER), .FAST_PERIOD_TICKS(FAST), .ACCEL_AFTER(ACC), .ACTIVE_LOW(AL)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference state: synchroniser/debounce per the acceptance rule, repeats derived arithmetically
    // from the start of the current stable-pressed run.
    int         m_cyc;
    int         m_age;
    logic       m_sync1 [2];
    logic       m_raw   [2];
    logic       m_stable[2];
    logic       m_prev  [2];
    int         m_db    [2];
    int         m_start [2];
    logic [1:0] e_level;
    logic [1:0] e_pulse;
    logic [1:0] e_held;

    // Number of repeat events whose tick offset from the press is <= t.
    function automatic int reps_by(input int t);
        int n;
        int off;
        n   = 0;
        off = DELAY;
        if (t < 0) return 0;
        while (off <= t) begin
            n++;
            off += (ACC != 0 && n >= ACC) ? FAST : PER;
        end
        return n;
    endfunction

    task automatic model_edge();
        logic       tick;
        logic       st;
        logic [1:0] pressed;
        int         d;
        int         t;
        pressed = bus.i_buttons ^ AL;
        if (rst) begin
            m_age   = 0;
            e_level = '0;
            e_pulse = '0;
            e_held  = '0;
            for (int ch = 0; ch < 2; ch++) begin
                m_sync1[ch]  = 1'b0;
                m_raw[ch]    = 1'b0;
                m_stable[ch] = 1'b0;
                m_prev[ch]   = 1'b0;
                m_db[ch]     = 0;
            end
        end else begin
            tick = (m_age % TD) == TD - 1;
            for (int ch = 0; ch < 2; ch++) begin
                st = m_stable[ch];
                if (!st) begin
                    e_level[ch] = 1'b0;
                    e_pulse[ch] = 1'b0;
                    e_held[ch]  = 1'b0;
                end else if (!m_prev[ch]) begin
                    m_start[ch] = m_cyc;
                    e_level[ch] = 1'b1;
                    e_pulse[ch] = 1'b1;
                    e_held[ch]  = 1'b1;
                end else begin
                    d = m_cyc + 1 - m_start[ch];
                    t = d / TD;
                    e_pulse[ch] = (d % TD == 0) && (reps_by(t) > reps_by(t - 1));
                    e_level[ch] = ((1 + reps_by(t)) % 2) == 1;
                    e_held[ch]  = 1'b1;
                end
                if (m_raw[ch] == st) begin
                    m_db[ch] = 0;
                end else if (tick) begin
                    if (m_db[ch] == DB - 1) begin
                        m_stable[ch] = m_raw[ch];
                        m_db[ch]     = 0;
                    end else begin
                        m_db[ch]++;
                    end
                end
                m_raw[ch]   = m_sync1[ch];
                m_sync1[ch] = pressed[ch];
                m_prev[ch]  = st;
            end
            m_age++;
        end
        m_cyc++;
    endtask

    task automatic compare();
        for (int ch = 0; ch < 2; ch++) begin
            n_checks++;
            assert (bus.o_pulse[ch] === e_pulse[ch]) else begin
                n_errors++;
                $error("FAIL pulse ch%0d cyc %0d: observed %b expected %b", ch, m_cyc, bus.o_pulse[ch], e_pulse[ch]);
            end
            n_checks++;
            assert (bus.o_level[ch] === e_level[ch]) else begin
                n_errors++;
                $error("FAIL level ch%0d cyc %0d: observed %b expected %b", ch, m_cyc, bus.o_level[ch], e_level[ch]);
            end
            n_checks++;
            assert (bus.o_held[ch] === e_held[ch]) else begin
                n_errors++;
                $error("FAIL held ch%0d cyc %0d: observed %b expected %b", ch, m_cyc, bus.o_held[ch], e_held[ch]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic [1:0] pressed);
        bus.i_buttons = pressed ^ AL;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        n_checks = 0;
        n_errors = 0;
        m_cyc    = 0;
        e_level  = '0;
        e_pulse  = '0;
        e_held   = '0;
        drive(2'b00);

        // Reset with both buttons released, then idle.
        run(3);
        rst = 1'b0;
        run(100);

        // Bounce on ch0: 2 ticks pressed, 1 tick released, then steady.
        drive(2'b01);
        run(8);
        drive(2'b00);
        run(4);
        drive(2'b01);
        pulses0 = 0;
        for (int i = 0; i < 26; i++) begin
            step();
            if (bus.o_pulse[0]) pulses0++;
        end
        n_checks++;
        assert (pulses0 === 1) else begin
            n_errors++;
            $error("FAIL bounce_pulses: observed %0d expected 1", pulses0);
        end

        // Long hold into fast repeat, release mid-repeat, re-press restarts slow.
        run(80);
        drive(2'b00);
        run(30);
        drive(2'b01);
        run(120);
        drive(2'b00);
        run(30);

        // Both channels pressed in the same cycle.
        drive(2'b11);
        run(100);
        drive(2'b00);
        run(30);

        // Reset during HOLD with ch1 still pressed.
        drive(2'b10);
        run(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        assert (bus.o_held === 2'b00) else begin
            n_errors++;
            $error("FAIL reset_held: observed %b expected 00", bus.o_held);
        end
        run(80);
        drive(2'b00);
        run(30);

        // Random press patterns and durations, occasional reset.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            drive(2'($urandom_range(0, 3)));
            run($urandom_range(1, 70));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
